// File: rtl/ucsbece154_sdram_responder.sv
// ucsbece154_sdram_responder
//
// Memory-side responder for the instruction-fetch block-refill protocol. A block read request
// is answered after an SDRAM-like latency (shorter when the request hits the currently open
// row). The block is then streamed back one 32-bit word per cycle with DataReady high. A
// preload port lets benches initialise the backing store.
//
// Optional feature macro: CRITICAL_WORD_FIRST_EN
//   defined   - the burst starts at the requested word and wraps within the block
//   undefined - the burst always starts at block word 0
//
// Ports:
//   Clk          in   1   clock, rising edge
//   Reset        in   1   synchronous, active-high
//   ReadRequest  in   1   block read request (sampled only in IDLE)
//   ReadAddress  in   32  byte address of the requested word
//   DataOut      out  32  burst data word (holds last beat when DataReady=0)
//   DataReady    out  1   DataOut valid this cycle
//   Busy         out  1   transaction in progress (WAIT or BURST)
//   LoadEnable   in   1   preload write strobe (honoured only in IDLE)
//   LoadAddress  in   32  preload byte address
//   LoadData     in   32  preload word

module ucsbece154_sdram_responder #(
    parameter int unsigned MEM_WORDS   = 16384,
    parameter int unsigned BLOCK_WORDS = 4,
    parameter int unsigned ROW_WORDS   = 256,
    parameter int unsigned T_ROW_MISS  = 10,
    parameter int unsigned T_ROW_HIT   = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        ReadRequest,
    input  logic [31:0] ReadAddress,
    output logic [31:0] DataOut,
    output logic        DataReady,
    output logic        Busy,
    input  logic        LoadEnable,
    input  logic [31:0] LoadAddress,
    input  logic [31:0] LoadData
);

    localparam int unsigned AddrW   = $clog2(MEM_WORDS);
    localparam int unsigned IdxW    = $clog2(BLOCK_WORDS);
    localparam int unsigned BlkW    = AddrW - IdxW;
    localparam int unsigned RowBits = $clog2(ROW_WORDS);
    localparam int unsigned CntW    = $clog2(T_ROW_MISS);
    localparam int unsigned BeatW   = IdxW + 1;

    // The wait counter is loaded with latency-2: one cycle is spent on the accepting edge and
    // the first beat is registered on the edge where the counter reaches zero.
    localparam logic [CntW-1:0]  HitCnt   = CntW'(T_ROW_HIT - 2);
    localparam logic [CntW-1:0]  MissCnt  = CntW'(T_ROW_MISS - 2);
    localparam logic [BeatW-1:0] BeatsAll = BeatW'(BLOCK_WORDS);

    typedef enum logic [1:0] {StIdle, StWait, StBurst} state_e;

    state_e state_q, state_d;

    logic [BlkW-1:0]  blk_q, blk_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic [AddrW-1:0] row_q, row_d;
    logic [AddrW-1:0] open_row_q, open_row_d;
    logic             open_valid_q, open_valid_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [BeatW-1:0] beat_q, beat_d;
    logic [31:0]      data_out_q, data_out_d;
    logic             data_ready_q, data_ready_d;
    logic             busy_q, busy_d;

    logic [31:0] mem [MEM_WORDS];

    logic [AddrW-1:0] req_word;
    logic [AddrW-1:0] req_row;
    logic [AddrW-1:0] load_word;
    logic [IdxW-1:0]  rd_idx;
    logic [AddrW-1:0] rd_addr;
    logic [31:0]      rd_word;
    logic             row_hit;
    logic             mem_we;

    // Upper address bits fall away so accesses wrap modulo MEM_WORDS.
    assign req_word  = ReadAddress[AddrW+1:2];
    assign load_word = LoadAddress[AddrW+1:2];
    assign req_row   = req_word >> RowBits;
    assign row_hit   = open_valid_q && (req_row == open_row_q);

`ifdef CRITICAL_WORD_FIRST_EN
    assign rd_idx = idx_q + beat_q[IdxW-1:0];
`else
    assign rd_idx = beat_q[IdxW-1:0];
`endif

    assign rd_addr = {blk_q, rd_idx};
    assign rd_word = mem[rd_addr];
    assign mem_we  = (state_q == StIdle) && LoadEnable;

    logic unused_bits;
    assign unused_bits = ^{ReadAddress[31:AddrW+2], ReadAddress[1:0],
                           LoadAddress[31:AddrW+2], LoadAddress[1:0], idx_q};

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (ReadRequest) state_d = StWait;
            StWait:  if (cnt_q == '0) state_d = StBurst;
            StBurst: if (beat_q == BeatsAll) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output and datapath next-state logic
    always_comb begin
        blk_d        = blk_q;
        idx_d        = idx_q;
        row_d        = row_q;
        open_row_d   = open_row_q;
        open_valid_d = open_valid_q;
        cnt_d        = cnt_q;
        beat_d       = beat_q;
        data_out_d   = data_out_q;
        data_ready_d = 1'b0;
        busy_d       = busy_q;
        unique case (state_q)
            StIdle: begin
                busy_d = 1'b0;
                if (ReadRequest) begin
                    blk_d  = req_word[AddrW-1:IdxW];
                    idx_d  = req_word[IdxW-1:0];
                    row_d  = req_row;
                    cnt_d  = row_hit ? HitCnt : MissCnt;
                    beat_d = '0;
                    busy_d = 1'b1;
                end
            end
            StWait: begin
                busy_d = 1'b1;
                if (cnt_q == '0) begin
                    // First beat is registered on this edge.
                    data_ready_d = 1'b1;
                    data_out_d   = rd_word;
                    beat_d       = beat_q + BeatW'(1);
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StBurst: begin
                if (beat_q == BeatsAll) begin
                    busy_d       = 1'b0;
                    open_row_d   = row_q;
                    open_valid_d = 1'b1;
                end else begin
                    busy_d       = 1'b1;
                    data_ready_d = 1'b1;
                    data_out_d   = rd_word;
                    beat_d       = beat_q + BeatW'(1);
                end
            end
            default: busy_d = 1'b0;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            blk_q        <= '0;
            idx_q        <= '0;
            row_q        <= '0;
            open_row_q   <= '0;
            open_valid_q <= 1'b0;
            cnt_q        <= '0;
            beat_q       <= '0;
            data_out_q   <= '0;
            data_ready_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            blk_q        <= blk_d;
            idx_q        <= idx_d;
            row_q        <= row_d;
            open_row_q   <= open_row_d;
            open_valid_q <= open_valid_d;
            cnt_q        <= cnt_d;
            beat_q       <= beat_d;
            data_out_q   <= data_out_d;
            data_ready_q <= data_ready_d;
            busy_q       <= busy_d;
        end
    end

    // Backing store; never cleared by Reset.
    always_ff @(posedge Clk) begin
        if (mem_we) begin
            mem[load_word] <= LoadData;
        end
    end

    assign DataOut   = data_out_q;
    assign DataReady = data_ready_q;
    assign Busy      = busy_q;

endmodule

// File: tb/tb_ucsbece154_sdram_responder.sv
// Self-checking bench for ucsbece154_sdram_responder (default parameters).
module tb_ucsbece154_sdram_responder;

    logic        Clk;
    logic        Reset;
    logic        ReadRequest;
    logic [31:0] ReadAddress;
    logic [31:0] DataOut;
    logic        DataReady;
    logic        Busy;
    logic        LoadEnable;
    logic [31:0] LoadAddress;
    logic [31:0] LoadData;

    int errors = 0;
    int checks = 0;

    logic [31:0] sb_q[$];

    typedef struct {
        logic [31:0]      addr;
        int               lat;
        logic [3:0][31:0] words;
    } vec_t;

    vec_t vecs[6];

    ucsbece154_sdram_responder dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .ReadRequest (ReadRequest),
        .ReadAddress (ReadAddress),
        .DataOut     (DataOut),
        .DataReady   (DataReady),
        .Busy        (Busy),
        .LoadEnable  (LoadEnable),
        .LoadAddress (LoadAddress),
        .LoadData    (LoadData)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard: every beat the DUT presents is compared with the next expected word.
    always @(negedge Clk) begin
        if (DataReady === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_beat", DataReady, 1'b0);
            end else begin
                check("beat_data", DataOut, sb_q.pop_front());
            end
        end
    end

    function automatic vec_t mk(input logic [31:0] a, input int l, input logic [31:0] w0,
                                input logic [31:0] w1, input logic [31:0] w2,
                                input logic [31:0] w3);
        vec_t v;
        v.addr     = a;
        v.lat      = l;
        v.words[0] = w0;
        v.words[1] = w1;
        v.words[2] = w2;
        v.words[3] = w3;
        return v;
    endfunction

    task automatic preload(input logic [31:0] addr, input logic [31:0] data);
        LoadEnable  = 1'b1;
        LoadAddress = addr;
        LoadData    = data;
        @(posedge Clk);
        #1;
        LoadEnable = 1'b0;
    endtask

    // Called just after a rising edge. noise pulses ReadRequest in WAIT and BURST and tries a
    // preload during BURST; ld issues a preload on the same edge as the request.
    task automatic run_txn(input logic [31:0] addr, input int lat, input logic [3:0][31:0] w,
                           input bit noise, input bit ld, input logic [31:0] ld_addr,
                           input logic [31:0] ld_data);
        int k;
        for (int b = 0; b < 4; b++) sb_q.push_back(w[b]);
        ReadRequest = 1'b1;
        ReadAddress = addr;
        if (ld) begin
            LoadEnable  = 1'b1;
            LoadAddress = ld_addr;
            LoadData    = ld_data;
        end
        @(posedge Clk);
        #1;
        ReadRequest = 1'b0;
        LoadEnable  = 1'b0;
        k = 0;
        do begin
            @(negedge Clk);
            k++;
            if (DataReady !== 1'b1) begin
                check("busy_wait", Busy, 1'b1);
                if (noise && k == 2) ReadRequest = 1'b1;
                if (noise && k == 3) ReadRequest = 1'b0;
            end
        end while (DataReady !== 1'b1 && k < 40);
        check("latency", 32'(k), 32'(lat));
        for (int b = 0; b < 4; b++) begin
            if (b > 0) @(negedge Clk);
            check("beat_ready", DataReady, 1'b1);
            check("beat_busy", Busy, 1'b1);
            if (noise && b == 0) begin
                ReadRequest = 1'b1;
                LoadEnable  = 1'b1;
                LoadAddress = 32'h104;
                LoadData    = 32'hDEAD_BEEF;
            end
            if (noise && b == 1) begin
                ReadRequest = 1'b0;
                LoadEnable  = 1'b0;
            end
        end
        @(negedge Clk);
        check("end_ready", DataReady, 1'b0);
        check("end_busy", Busy, 1'b0);
        check("hold_data", DataOut, w[3]);
        @(posedge Clk);
        #1;
    endtask

    logic [3:0][31:0] blk_a;

    initial begin
        int k;
        Reset       = 1'b1;
        ReadRequest = 1'b0;
        ReadAddress = '0;
        LoadEnable  = 1'b0;
        LoadAddress = '0;
        LoadData    = '0;

        blk_a[0] = 32'hA0;
        blk_a[1] = 32'hA1;
        blk_a[2] = 32'hA2;
        blk_a[3] = 32'hA3;

`ifdef CRITICAL_WORD_FIRST_EN
        vecs[0] = mk(32'h108, 10, 32'hA2, 32'hA3, 32'hA0, 32'hA1);
        vecs[4] = mk(32'h10C, 4, 32'hA3, 32'hA0, 32'hA1, 32'hA2);
`else
        vecs[0] = mk(32'h108, 10, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
        vecs[4] = mk(32'h10C, 4, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
`endif
        vecs[1] = mk(32'h200, 4, 32'hB0, 32'hB1, 32'hB2, 32'hB3);      // row 0 hit
        vecs[2] = mk(32'h400, 10, 32'hC0, 32'hC1, 32'hC2, 32'hC3);     // row 1 miss
        vecs[3] = mk(32'h000, 10, 32'hD0, 32'hD1, 32'hD2, 32'hD3);     // back to row 0: miss
        vecs[5] = mk(32'h0001_0100, 4, 32'hA0, 32'hA1, 32'hA2, 32'hA3); // wraps to word 0x40

        repeat (2) @(posedge Clk);
        #1;
        check("reset_dataout", DataOut, 32'h0);
        check("reset_ready", DataReady, 1'b0);
        check("reset_busy", Busy, 1'b0);
        Reset = 1'b0;

        for (int i = 0; i < 4; i++) begin
            preload(32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
            preload(32'h200 + 32'(4 * i), 32'hB0 + 32'(i));
            preload(32'h400 + 32'(4 * i), 32'hC0 + 32'(i));
            preload(32'h000 + 32'(4 * i), 32'hD0 + 32'(i));
        end

        for (int i = 0; i < 6; i++) begin
            run_txn(vecs[i].addr, vecs[i].lat, vecs[i].words, 1'b0, 1'b0, '0, '0);
        end

        // Reset on the second beat; only two beats may appear.
        sb_q.push_back(32'hA0);
        sb_q.push_back(32'hA1);
        ReadRequest = 1'b1;
        ReadAddress = 32'h100;
        @(posedge Clk);
        #1;
        ReadRequest = 1'b0;
        k = 0;
        do begin
            @(negedge Clk);
            k++;
        end while (DataReady !== 1'b1 && k < 40);
        check("rst_seq_latency", 32'(k), 32'd4);
        @(negedge Clk);
        check("rst_seq_beat2", DataReady, 1'b1);
        Reset = 1'b1;
        @(negedge Clk);
        check("rst_seq_ready", DataReady, 1'b0);
        check("rst_seq_busy", Busy, 1'b0);
        Reset = 1'b0;
        repeat (6) begin
            @(negedge Clk);
            check("rst_seq_no_beats", DataReady, 1'b0);
        end
        @(posedge Clk);
        #1;

        // Open row was invalidated by the reset: same row now misses.
        run_txn(32'h100, 10, blk_a, 1'b0, 1'b0, '0, '0);
        // Requests and preload while busy must be ignored.
        run_txn(32'h100, 4, blk_a, 1'b1, 1'b0, '0, '0);
        run_txn(32'h100, 4, blk_a, 1'b0, 1'b0, '0, '0);
        // Preload and request on the same edge: the burst sees the new word.
        blk_a[1] = 32'h55;
        run_txn(32'h100, 4, blk_a, 1'b0, 1'b1, 32'h104, 32'h55);

        @(negedge Clk);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
